// File: rtl/weight_pkg.sv
// Shared types and constants for the weight loader: FSM states, default
// weight width, reset values of the inhibition matrix and the counter-to-entry map.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam int WIDTH = 5;
    localparam logic [WIDTH-1:0] DIAG_INIT = 5'b01000;
    localparam logic [WIDTH-1:0] OFF_INIT  = 5'b11110;

    // Upper bound on the matrix dimension, so the triangle walk has a static loop.
    localparam int MAX_N = 16;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } pos_t;

    // Map stream word k to its (row, col): row-major over the full matrix, or
    // row-major over the upper triangle (i <= j) when tri_mode is set.
    function automatic pos_t index_to_pos(input int k, input int n, input bit tri_mode);
        pos_t p;
        int   rem;
        bit   found;
        p     = '0;
        rem   = k;
        found = 1'b0;
        if (!tri_mode) begin
            p.row = 8'(k / n);
            p.col = 8'(k % n);
        end else begin
            for (int r = 0; r < MAX_N; r++) begin
                if (!found && r < n) begin
                    if (rem < n - r) begin
                        p.row = 8'(r);
                        p.col = 8'(r + rem);
                        found = 1'b1;
                    end else begin
                        rem = rem - (n - r);
                    end
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Valid/ready weight stream: the master (source) drives in_valid and in_data,
// the slave (weight_loader) drives in_ready.
interface weight_loader_if
    import weight_pkg::*;
#(
    parameter int WIDTH = weight_pkg::WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/weight_bank.sv
// N x N bank of weight registers with per-entry write enables; resets to the
// default inhibition matrix (DIAG_INIT on the diagonal, OFF_INIT elsewhere).
module weight_bank
    import weight_pkg::*;
#(
    parameter int               N         = 4,
    parameter int               WIDTH     = weight_pkg::WIDTH,
    parameter logic [WIDTH-1:0] DIAG_INIT = weight_pkg::DIAG_INIT,
    parameter logic [WIDTH-1:0] OFF_INIT  = weight_pkg::OFF_INIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*N-1:0]         wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [N*N*WIDTH-1:0]   w_flat
);

    // Entry e sits at bits [e*WIDTH +: WIDTH], matching the flat output layout.
    logic [N*N-1:0][WIDTH-1:0] bank;

    // NOTE: unlike a RAM, this bank is reset on purpose; the default matrix is
    // a functional value the datapath relies on from the first cycle.
    always_ff @(posedge clk) begin
        for (int e = 0; e < N*N; e++) begin
            if (!rst) begin
                bank[e] <= ((e / N) == (e % N)) ? DIAG_INIT : OFF_INIT;
            end else if (wr_en[e]) begin
                bank[e] <= wr_data;
            end
        end
    end

    assign w_flat = bank;

endmodule

// File: rtl/weight_loader.sv
// Serial loader for the weight matrix: a start pulse opens a load, each stream
// word is written row-major into weight_bank. Define WEIGHT_LOADER_SYMM_EN to
// stream only the upper triangle and mirror each word into (j,i).
module weight_loader
    import weight_pkg::*;
#(
    parameter int               N         = 4,
    parameter int               WIDTH     = weight_pkg::WIDTH,
    parameter logic [WIDTH-1:0] DIAG_INIT = weight_pkg::DIAG_INIT,
    parameter logic [WIDTH-1:0] OFF_INIT  = weight_pkg::OFF_INIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    weight_loader_if.slave       in_if,
    output logic [N*N*WIDTH-1:0] w_flat,
    output logic                 busy,
    output logic                 loaded
);

`ifdef WEIGHT_LOADER_SYMM_EN
    localparam bit SYMM  = 1'b1;
    localparam int WORDS = N * (N + 1) / 2;
`else
    localparam bit SYMM  = 1'b0;
    localparam int WORDS = N * N;
`endif

    localparam int CNT_W  = $clog2(N*N + 1);
    localparam int ADDR_W = (N*N > 1) ? $clog2(N*N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ready;
    logic [N*N-1:0]    wr_en;
    logic [ADDR_W-1:0] addr, addr_mirror;
    pos_t              pos;

    always_comb begin
        pos         = index_to_pos(int'(cnt), N, SYMM);
        addr        = ADDR_W'(int'(pos.row) * N + int'(pos.col));
        addr_mirror = ADDR_W'(int'(pos.col) * N + int'(pos.row));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output is assigned a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        busy       = 1'b0;
        loaded     = 1'b0;
        wr_en      = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (in_if.in_valid) begin
                    wr_en[addr] = 1'b1;
                    if (SYMM) wr_en[addr_mirror] = 1'b1;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST) state_next = DONE;
                end
            end
            DONE: begin
                loaded = 1'b1;
                if (start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_if.in_ready = ready;

    weight_bank #(
        .N         (N),
        .WIDTH     (WIDTH),
        .DIAG_INIT (DIAG_INIT),
        .OFF_INIT  (OFF_INIT)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_if.in_data),
        .w_flat  (w_flat)
    );

endmodule

// File: doc/weight_loader.md
# weight_loader

Serial writer for the network's weight matrix: accepts weights one word at a time over a valid/ready stream and writes them, row-major, into an N×N bank of weight registers. The bank drives the full matrix in parallel to the neuron datapath. On reset the bank holds the default inhibition matrix, so the datapath always sees a legal matrix before, during and after a load. A load is started by a one-cycle `start` pulse and reported complete with `loaded`.

## Interface
- `N`, 4, matrix dimension; the bank holds N·N entries.
- `WIDTH`, 5, weight width in bits (two's complement).
- `DIAG_INIT`, 5'b01000, reset value of every diagonal entry.
- `OFF_INIT`, 5'b11110, reset value of every off-diagonal entry.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a load.
- `in_valid`  in  1  `in_data` holds a weight.
- `in_ready`  out  1  loader accepts a weight this cycle.
- `in_data`  in  WIDTH  weight word.
- `w_flat`  out  N·N·WIDTH  entry (i,j) at bits [(i·N+j)·WIDTH +: WIDTH].
- `busy`  out  1  load in progress.
- `loaded`  out  1  last load completed and the bank is unchanged since.

## Operation
- FSM states are IDLE, LOAD and DONE.
- Reset (`rst`=0 at a rising edge):
  - state goes to IDLE, word counter to 0;
  - `in_ready`=0, `busy`=0, `loaded`=0;
  - every diagonal entry is set to `DIAG_INIT` and every off-diagonal entry to `OFF_INIT`.
- IDLE:
  - `start`=1 moves to LOAD and clears the counter;
  - `in_valid` is ignored.
- LOAD:
  - `in_ready`=1 and `busy`=1;
  - each transfer (`in_valid` && `in_ready`) writes `in_data` to the entry addressed by the counter, then increments the counter;
  - the counter maps row-major: counter k addresses (k/N, k%N);
  - the transfer of word N·N−1 moves to DONE;
  - `start` is ignored while in LOAD;
  - gaps in `in_valid` are allowed; the counter holds during a gap.
- DONE:
  - `loaded`=1, `in_ready`=0, `busy`=0;
  - `start`=1 re-enters LOAD, clears the counter and drops `loaded`.
- Entries that have not yet been overwritten keep their previous value. A partially loaded bank is therefore a mix of old and new entries, and `loaded`=0 flags it.
- Weights are stored verbatim. No arithmetic, saturation or sign conversion is applied.

## Timing
- A transfer at edge t makes the new entry visible on `w_flat` after edge t (one-cycle write latency).
- `loaded` rises in the cycle after the final transfer. `in_ready` falls in that same cycle.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- Minimum load time is N·N cycles after the `start` edge, plus one cycle until `loaded`.
- Reset mid-load:
  - reset wins over any simultaneous transfer or `start`;
  - the bank returns to the default matrix;
  - a new load needs a new `start`.
- The counter is ⌈log2(N·N+1)⌉ bits and never wraps; it is cleared on every LOAD entry.

## Configuration
- `WEIGHT_LOADER_SYMM_EN` defined:
  - symmetric mode; only the upper triangle (i≤j) is streamed, row-major, N·(N+1)/2 words (10 for N=4);
  - each transfer writes both (i,j) and (j,i) in the same cycle;
  - DONE is entered after the last triangle word.
- Not defined: full N·N stream as described above.
- Ports and reset behaviour are identical in both builds.

## Structure
- Package `weight_pkg` holds:
  - the state enum (IDLE/LOAD/DONE);
  - default `WIDTH`;
  - `DIAG_INIT` and `OFF_INIT` constants;
  - a function mapping a counter value to (row, col) for both full and triangle order.
- Sub-module `weight_bank`: N·N enable-gated registers with per-entry write enables and a diagonal/off-diagonal reset value. The FSM and counter stay in `weight_loader`.

## Test plan
- Reset then idle → `w_flat` entries (0,0),(1,1),(2,2),(3,3) equal 5'b01000 and all others equal 5'b11110; `loaded`=0, `in_ready`=0.
- `start`, then 16 back-to-back words 0..15 → entry (i,j) equals i·4+j; `loaded` rises exactly one cycle after the 16th transfer; `in_ready` is low thereafter.
- Same load with `in_valid` toggling every other cycle → identical final bank; `loaded` appears 31 cycles after the first transfer edge.
- Reset asserted after 7 transfers → bank returns to the default matrix, `busy`=0; words presented afterwards are not accepted until a new `start`.
- From DONE, `start` plus 3 words 5'b00001 → entries (0,0..2)=1, entry (0,3) keeps its prior value, `loaded`=0 throughout.
- With `WEIGHT_LOADER_SYMM_EN`, 10 words 1..10 → (0,1)=(1,0)=2 and (3,3)=10; `loaded` follows the 10th transfer by one cycle.
